pong_sound_sequencer: RTL

Event-to-playback sequencer that sits directly upstream of the Pong audio playback stage. Game logic raises `hit` when the ball strikes a paddle or wall and `score` when a point is won. This block arbitrates those events and drives the playback stage's `enable` and `switchAudioOut` inputs. It times each sound so that `enable` stays high for exactly one full ROM pass and is dropped low long enough to rewind the playback address before every new sound.

---
 rtl/pong_sound_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pong_sound_sequencer.sv
// pong_sound_sequencer: turns hit/score events into timed enable and
// switchAudioOut controls for the Pong audio playback stage. Each sound is
// preceded by a short low gap on enable so that the playback address rewinds.
// Then enable is held for exactly one full ROM pass.
module pong_sound_sequencer #(
  parameter int SAMPLE_DIV = 1135,
  parameter int BOINK_LEN  = 15436,
  parameter int WIN_LEN    = 65405,
  parameter int GAP_CYCLES = 2
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       hit,
  input  logic       score,
  input  logic       mute,
  output logic       enable,
  output logic       switchAudioOut,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REARM = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t           state;
  logic             hit_q;
  logic             score_q;
  logic [DIV_W-1:0] div_cnt;
  logic [22:0]      samp_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic        hit_ev;
  logic        score_ev;
  logic        start_win;
  logic        start_boink;
  logic [22:0] samp_next;
  logic [22:0] sel_len;

  // Event detection and arbitration. Score always wins. A hit starts a boink
  // from idle or retriggers a boink, but it never interrupts a win.
  always_comb begin
    hit_ev      = hit & ~hit_q;
    score_ev    = score & ~score_q;
    start_win   = score_ev;
    start_boink = hit_ev & ~score_ev & ((state == IDLE) | ~switchAudioOut);
    samp_next   = samp_cnt + 23'd1;
    sel_len     = switchAudioOut ? 23'(WIN_LEN) : 23'(BOINK_LEN);
  end

  assign state_dbg = state;

  // Sequencer FSM. Every output is registered here.
  // Priority within a cycle: mute, then a new or retriggered sound, then timing.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state          <= IDLE;
      hit_q          <= 1'b0;
      score_q        <= 1'b0;
      div_cnt        <= '0;
      samp_cnt       <= '0;
      gap_cnt        <= '0;
      enable         <= 1'b0;
      busy           <= 1'b0;
      switchAudioOut <= 1'b0;
    end else begin
      hit_q   <= hit;
      score_q <= score;
      if (mute) begin
        state  <= IDLE;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else if (start_win || start_boink) begin
        state          <= REARM;
        switchAudioOut <= start_win;
        gap_cnt        <= '0;
        enable         <= 1'b0;
        busy           <= 1'b1;
      end else begin
        case (state)
          REARM: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              state    <= PLAY;
              div_cnt  <= '0;
              samp_cnt <= '0;
              enable   <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
              div_cnt <= '0;
              if (samp_next == sel_len) begin
                state  <= IDLE;
                enable <= 1'b0;
                busy   <= 1'b0;
              end else begin
                samp_cnt <= samp_next;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
